// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields, memory handshake and control outputs between datapath and controller.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       illegal;
  logic       retired;
  logic [3:0] state_dbg;
  modport master (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a, alu_src_b,
           result_src, imm_src, alu_control, illegal, retired, state_dbg
  );
  modport slave (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a, alu_src_b,
           result_src, imm_src, alu_control, illegal, retired, state_dbg
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle RV32 subset control FSM with memory handshake, trap state and retire pulse.
module multicycle_controller (
  input logic clk,
  input logic reset,
  multicycle_controller_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
    EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10, TRAP = 4'd11
  } state_t;
  state_t state, next;
  logic illegal_q, pcw, irw, mw, rw, ret, adr;
  logic [1:0] sa, sb, rs, imm;
  logic [2:0] alu, alu_dec;
  logic alu_f3, is_sw;
  state_t dec_next;
  assign is_sw = bus.opcode == 7'b0100011;
  assign alu_f3 = bus.funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
  assign alu_dec = bus.funct3 == 3'b000 ? ((state == EXECR && bus.funct7b5) ? 3'b001 : 3'b000)
                 : bus.funct3 == 3'b010 ? 3'b101
                 : bus.funct3 == 3'b110 ? 3'b011
                 : bus.funct3 == 3'b111 ? 3'b010 : 3'b000;
  assign dec_next = (bus.opcode == 7'b0000011 || is_sw) ? (bus.funct3 == 3'b010 ? MEMADR : TRAP)
                  : bus.opcode == 7'b0110011 ? (alu_f3 ? EXECR : TRAP)
                  : bus.opcode == 7'b0010011 ? (alu_f3 ? EXECI : TRAP)
                  : bus.opcode == 7'b1100011 ? (bus.funct3 == 3'b000 ? BEQ : TRAP)
                  : bus.opcode == 7'b1101111 ? JAL : TRAP;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next;
      illegal_q <= next == TRAP;
    end
  end
  always_comb begin
    next = TRAP;
    {pcw, irw, mw, rw, ret, adr} = '0;
    {sa, sb, rs, imm} = '0;
    alu = 3'b000;
    case (state)
      FETCH: begin
        sb = 2'b10;
        rs = 2'b10;
        pcw = bus.mem_ready;
        irw = bus.mem_ready;
        next = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        sa = 2'b01;
        sb = 2'b01;
        imm = bus.opcode == 7'b1101111 ? 2'b11 : 2'b10;
        next = dec_next;
      end
      MEMADR: begin
        sa = 2'b10;
        sb = 2'b01;
        imm = is_sw ? 2'b01 : 2'b00;
        next = is_sw ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr = 1'b1;
        next = bus.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        rs = 2'b01;
        rw = 1'b1;
        ret = 1'b1;
        next = FETCH;
      end
      MEMWRITE: begin
        adr = 1'b1;
        mw = 1'b1;
        ret = bus.mem_ready;
        next = bus.mem_ready ? FETCH : MEMWRITE;
      end
      EXECR, EXECI: begin
        sa = 2'b10;
        sb = state == EXECI ? 2'b01 : 2'b00;
        alu = alu_dec;
        next = ALUWB;
      end
      ALUWB: begin
        rw = 1'b1;
        ret = 1'b1;
        next = FETCH;
      end
      BEQ: begin
        sa = 2'b10;
        alu = 3'b001;
        pcw = bus.zero;
        ret = 1'b1;
        next = FETCH;
      end
      JAL: begin
        sa = 2'b01;
        sb = 2'b10;
        pcw = 1'b1;
        next = ALUWB;
      end
      default: next = TRAP;
    endcase
  end
  // Write enables and the retire pulse are suppressed for the whole reset-low cycle.
  assign bus.pc_write = reset & pcw;
  assign bus.ir_write = reset & irw;
  assign bus.mem_write = reset & mw;
  assign bus.reg_write = reset & rw;
  assign bus.retired = reset & ret;
  assign bus.adr_src = adr;
  assign bus.alu_src_a = sa;
  assign bus.alu_src_b = sb;
  assign bus.result_src = rs;
  assign bus.imm_src = imm;
  assign bus.alu_control = alu;
  assign bus.illegal = illegal_q;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed instruction runs checked each cycle against a per-instruction state-path model.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int nret;
  logic [63:0] trace;
  multicycle_controller_if bus ();
  multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  // Expected outputs packed as {pcw,irw,mw,rw,adr,sa,sb,rs,imm,alu,illegal,retired}.
  function automatic logic [17:0] model(input int s, input logic z, input logic mr, input logic rn);
    logic pcw, irw, mw, rw, adr, ill, ret;
    logic [1:0] sa, sb, rs, imm;
    logic [2:0] alu;
    {pcw, irw, mw, rw, adr, ill, ret} = '0;
    {sa, sb, rs, imm} = '0;
    alu = 3'd0;
    case (s)
      0: begin sb = 2; rs = 2; pcw = mr; irw = mr; end
      1: begin sa = 1; sb = 1; imm = (bus.opcode == 7'h6F) ? 2'd3 : 2'd2; end
      2: begin sa = 2; sb = 1; imm = (bus.opcode == 7'h23) ? 2'd1 : 2'd0; end
      3: adr = 1;
      4: begin rs = 1; rw = 1; ret = 1; end
      5: begin adr = 1; mw = 1; ret = mr; end
      6, 7: begin
        sa = 2;
        sb = (s == 7) ? 2'd1 : 2'd0;
        case (bus.funct3)
          3'd0: alu = (s == 6 && bus.funct7b5) ? 3'd1 : 3'd0;
          3'd2: alu = 3'd5;
          3'd6: alu = 3'd3;
          3'd7: alu = 3'd2;
          default: alu = 3'd0;
        endcase
      end
      8: begin rw = 1; ret = 1; end
      9: begin sa = 2; alu = 1; pcw = z; ret = 1; end
      10: begin sa = 1; sb = 2; pcw = 1; end
      11: ill = 1;
      default: ;
    endcase
    if (!rn) {pcw, irw, mw, rw, ret} = '0;
    return {pcw, irw, mw, rw, adr, sa, sb, rs, imm, alu, ill, ret};
  endfunction

  task automatic cycle(input int es, input logic mr, input logic rn);
    logic [17:0] act, exp;
    bus.mem_ready = mr;
    reset = rn;
    @(negedge clk);
    exp = model(es, bus.zero, mr, rn);
    act = {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write, bus.adr_src, bus.alu_src_a,
           bus.alu_src_b, bus.result_src, bus.imm_src, bus.alu_control, bus.illegal, bus.retired};
    checks += 2;
    if (bus.state_dbg !== 4'(es)) begin
      errors++;
      $display("FAIL state t=%0t got %0d exp %0d", $time, bus.state_dbg, es);
    end
    if (act !== exp) begin
      errors++;
      $display("FAIL outputs t=%0t state %0d got %b exp %b", $time, es, act, exp);
    end
    trace = {trace[59:0], bus.state_dbg};
    nret += int'(bus.retired);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z,
                     input int fw, input int mw, input bit chk_tr, input logic [63:0] exp_tr);
    int es[$];
    bit mq[$];
    bit alu_ok, trapped;
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7b5 = f7;
    bus.zero = z;
    alu_ok = f3 inside {3'd0, 3'd2, 3'd6, 3'd7};
    trapped = 1'b0;
    repeat (fw) begin es.push_back(0); mq.push_back(0); end
    es.push_back(0); mq.push_back(1);
    es.push_back(1); mq.push_back(1);
    if ((op == 7'h03 || op == 7'h23) && f3 == 3'd2) begin
      es.push_back(2); mq.push_back(1);
      repeat (mw) begin es.push_back(op == 7'h23 ? 5 : 3); mq.push_back(0); end
      es.push_back(op == 7'h23 ? 5 : 3); mq.push_back(1);
      if (op == 7'h03) begin es.push_back(4); mq.push_back(1); end
    end else if ((op == 7'h33 || op == 7'h13) && alu_ok) begin
      es.push_back(op == 7'h33 ? 6 : 7); mq.push_back(1);
      es.push_back(8); mq.push_back(1);
    end else if (op == 7'h63 && f3 == 3'd0) begin
      es.push_back(9); mq.push_back(1);
    end else if (op == 7'h6F) begin
      es.push_back(10); mq.push_back(1);
      es.push_back(8); mq.push_back(1);
    end else begin
      trapped = 1'b1;
      es.push_back(11); mq.push_back(1);
    end
    trace = '0;
    nret = 0;
    foreach (es[i]) cycle(es[i], mq[i], 1'b1);
    if (trapped) begin
      repeat (10) cycle(11, 1'b1, 1'b1);
      cycle(11, 1'b1, 1'b0);
    end
    check("retire_count", 64'(nret), trapped ? 64'd0 : 64'd1);
    if (chk_tr) check("state_trace", trace, exp_tr);
  endtask

  initial begin
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = 7'h33;
    bus.funct3 = 3'd0;
    bus.funct7b5 = 1'b0;
    bus.zero = 1'b0;
    @(posedge clk);
    #1;
    cycle(0, 1'b1, 1'b0);
    cycle(0, 1'b1, 1'b0);
    run(7'h33, 3'd0, 1'b0, 1'b0, 0, 0, 1'b1, 64'h0168);
    run(7'h33, 3'd0, 1'b1, 1'b0, 1, 0, 1'b0, 64'h0);
    run(7'h33, 3'd2, 1'b0, 1'b0, 0, 0, 1'b0, 64'h0);
    run(7'h33, 3'd6, 1'b0, 1'b0, 0, 0, 1'b0, 64'h0);
    run(7'h33, 3'd7, 1'b1, 1'b0, 2, 0, 1'b0, 64'h0);
    run(7'h13, 3'd0, 1'b1, 1'b0, 0, 0, 1'b1, 64'h0178);
    run(7'h13, 3'd2, 1'b0, 1'b0, 0, 0, 1'b0, 64'h0);
    run(7'h03, 3'd2, 1'b0, 1'b0, 0, 3, 1'b1, 64'h01233334);
    run(7'h23, 3'd2, 1'b0, 1'b0, 0, 2, 1'b1, 64'h012555);
    run(7'h63, 3'd0, 1'b0, 1'b1, 0, 0, 1'b1, 64'h019);
    run(7'h63, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0, 64'h0);
    run(7'h6F, 3'd5, 1'b1, 1'b0, 0, 0, 1'b1, 64'h01A8);
    run(7'h7F, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0, 64'h0);
    run(7'h33, 3'd1, 1'b0, 1'b0, 0, 0, 1'b0, 64'h0);
    run(7'h03, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0, 64'h0);
    run(7'h63, 3'd1, 1'b0, 1'b0, 0, 0, 1'b0, 64'h0);
    bus.opcode = 7'h23;
    bus.funct3 = 3'd2;
    trace = '0;
    cycle(0, 1'b1, 1'b1);
    cycle(1, 1'b1, 1'b1);
    cycle(2, 1'b1, 1'b1);
    cycle(5, 1'b0, 1'b1);
    cycle(5, 1'b0, 1'b0);
    check("sw_abort_trace", trace, 64'h01255);
    run(7'h33, 3'd0, 1'b0, 1'b0, 0, 0, 1'b1, 64'h0168);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none.
REQ-002 Clocking: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 opcode  in  7  instruction bits [6:0] from the instruction register.
REQ-006 funct3  in  3  instruction bits [14:12].
REQ-007 funct7b5  in  1  instruction bit 30.
REQ-008 zero  in  1  ALU zero flag, combinational from the current cycle.
REQ-009 mem_ready  in  1  memory handshake; the access completes in any cycle it is 1.
REQ-010 pc_write, ir_write, mem_write, reg_write  out  1 each  write enables.
REQ-011 adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut register.
REQ-012 alu_src_a  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1.
REQ-013 alu_src_b  out  2  ALU B select: 00 = rs2, 01 = immExt, 10 = constant 4.
REQ-014 result_src  out  2  result select: 00 = ALUOut register, 01 = memory data, 10 = ALU result direct.
REQ-015 imm_src  out  2  extend select: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-016 alu_control  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
REQ-017 illegal  out  1  sticky trap flag.
REQ-018 retired  out  1  one-cycle pulse when an instruction completes.
REQ-019 state_dbg  out  4  current state encoding.

Function
REQ-020 State encoding:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5
- EXECR = 6, EXECI = 7, ALUWB = 8, BEQ = 9, JAL = 10, TRAP = 11
- Codes 12-15 are unreachable; if ever entered, go to TRAP.
REQ-021 Output defaults: every output not listed for a state is 0.
REQ-022 Outputs are Moore decodes of the state, except:
- pc_write and ir_write in FETCH, gated by mem_ready;
- pc_write in BEQ, equal to zero;
- alu_control and imm_src, which also decode the instruction fields.
REQ-023 FETCH:
- adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_control = add, result_src = 10.
- ir_write = pc_write = mem_ready.
- Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
REQ-024 DECODE: alu_src_a = 01, alu_src_b = 01, add; imm_src = 11 if opcode = 1101111, else 10. Next state by opcode:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BEQ
- 1101111 -> JAL
- any other opcode -> TRAP
REQ-025 DECODE also goes to TRAP on an unsupported field combination:
- funct3 not in {000, 010, 110, 111} for opcode 0110011 or 0010011;
- funct3 != 010 for lw/sw;
- funct3 != 000 for beq.
REQ-026 MEMADR: alu_src_a = 10, alu_src_b = 01, add; imm_src = 01 for sw, 00 for lw. Next: MEMWRITE for sw, MEMREAD for lw.
REQ-027 MEMREAD: adr_src = 1, result_src = 00. Hold while mem_ready = 0; on mem_ready = 1 go to MEMWB.
REQ-028 MEMWB: result_src = 01, reg_write = 1; next FETCH.
REQ-029 MEMWRITE: adr_src = 1, mem_write = 1, held every cycle until mem_ready = 1; then go to FETCH.
REQ-030 EXECR: alu_src_a = 10, alu_src_b = 00. EXECI: alu_src_a = 10, alu_src_b = 01, imm_src = 00. Both go to ALUWB.
REQ-031 ALU decode in EXECR/EXECI, by funct3:
- 000 -> sub if EXECR and funct7b5 = 1, else add (EXECI ignores funct7b5);
- 010 -> slt; 110 -> or; 111 -> and.
REQ-032 ALUWB: result_src = 00, reg_write = 1; next FETCH.
REQ-033 BEQ: alu_src_a = 10, alu_src_b = 00, sub, result_src = 00, pc_write = zero; next FETCH.
REQ-034 JAL: alu_src_a = 01, alu_src_b = 10, add, result_src = 00, pc_write = 1; next ALUWB.
REQ-035 TRAP:
- All write enables are 0 and illegal = 1.
- TRAP is absorbing until reset.
REQ-036 retired = 1 for exactly one cycle in each of MEMWB, MEMWRITE-with-mem_ready, ALUWB and BEQ. JAL retires via its ALUWB, and never twice.

Reset
REQ-037 While reset = 0:
- pc_write, ir_write, mem_write, reg_write and retired are forced to 0 regardless of state.
REQ-038 At the first rising edge with reset = 0:
- state <= FETCH, illegal <= 0.
- This applies from any state, including mid-wait in MEMREAD/MEMWRITE and TRAP.
REQ-039 The first fetch occurs in the cycle after reset returns to 1.

Verification
REQ-040 add x3,x1,x2 (opcode 0110011, funct3 000, funct7b5 0), mem_ready = 1 -> states 0,1,6,8,0; reg_write = 1 only in ALUWB; alu_control = 000 in EXECR; retired pulses once.
REQ-041 lw with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, adr_src = 1 throughout; MEMWB follows with result_src = 01.
REQ-042 sw -> mem_write = 1 for every MEMWRITE cycle; reg_write never 1; next state FETCH.
REQ-043 beq with zero = 1 and zero = 0 -> pc_write is 1 and 0 respectively in BEQ; alu_control = 001.
REQ-044 opcode 1111111 -> TRAP with illegal = 1 held for 10 cycles; reset low one edge -> state 0, illegal 0.
REQ-045 reset low during MEMWRITE wait -> mem_write drops in the same cycle; state = FETCH after the edge.
